// File: rtl/serial_add_driver.sv
// Parallel front end for a bit-serial adder: streams two latched operands LSB-first,
// drives the adder carry clear/carry-in, and gathers the serial sum into a parallel result.
module serial_add_driver #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ser_clr,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  input  logic             ser_s,
  input  logic             ser_cout,
  output logic [WIDTH:0]   sum,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;

  assign ready   = (state == IDLE);
  assign done    = (state == DONE);
  assign ser_clr = (state != SHIFT);

  // Sum bits enter at the top and drift down, so bit 0 ends at position 0 after WIDTH shifts.
  always_comb begin
    res_next            = res >> 1;
    res_next[WIDTH-1]   = ser_s;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      res     <= '0;
      sum     <= '0;
      ser_a   <= 1'b0;
      ser_b   <= 1'b0;
      ser_cin <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SHIFT;
            count   <= '0;
            res     <= '0;
            ser_a   <= op_a[0];
            ser_b   <= op_b[0];
            ser_cin <= cin;
            a_sh    <= op_a >> 1;
            b_sh    <= op_b >> 1;
          end
        end
        SHIFT: begin
          res     <= res_next;
          ser_cin <= 1'b0;
          if (count == LAST) begin
            state <= DONE;
            sum   <= {ser_cout, res_next};
            ser_a <= 1'b0;
            ser_b <= 1'b0;
          end else begin
            count <= count + 1'b1;
            ser_a <= a_sh[0];
            ser_b <= b_sh[0];
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ser_a   <= 1'b0;
          ser_b   <= 1'b0;
          ser_cin <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_driver.sv
// Self-checking bench for serial_add_driver with a behavioural bit-serial adder
// attached to each instance (WIDTH = 4, 5 and 1).
module tb_serial_add_driver;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=4 instance
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, clr4, sa4, sb4, sc4, s4, co4, done4, carry4;
  logic [4:0] sum4;

  serial_add_driver #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ready(ready4),
    .op_a(a4), .op_b(b4), .cin(cin4),
    .ser_clr(clr4), .ser_a(sa4), .ser_b(sb4), .ser_cin(sc4),
    .ser_s(s4), .ser_cout(co4), .sum(sum4), .done(done4));

  assign s4  = sa4 ^ sb4 ^ (sc4 | carry4);
  assign co4 = (sa4 & sb4) | ((sa4 ^ sb4) & (sc4 | carry4));
  always @(posedge clk or negedge reset)
    if (!reset) carry4 <= 1'b0;
    else        carry4 <= clr4 ? 1'b0 : co4;

  // WIDTH=5 instance
  logic       start5 = 1'b0, cin5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       ready5, clr5, sa5, sb5, sc5, s5, co5, done5, carry5;
  logic [5:0] sum5;

  serial_add_driver #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .start(start5), .ready(ready5),
    .op_a(a5), .op_b(b5), .cin(cin5),
    .ser_clr(clr5), .ser_a(sa5), .ser_b(sb5), .ser_cin(sc5),
    .ser_s(s5), .ser_cout(co5), .sum(sum5), .done(done5));

  assign s5  = sa5 ^ sb5 ^ (sc5 | carry5);
  assign co5 = (sa5 & sb5) | ((sa5 ^ sb5) & (sc5 | carry5));
  always @(posedge clk or negedge reset)
    if (!reset) carry5 <= 1'b0;
    else        carry5 <= clr5 ? 1'b0 : co5;

  // WIDTH=1 instance
  logic       start1 = 1'b0, cin1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       ready1, clr1, sa1, sb1, sc1, s1, co1, done1, carry1;
  logic [1:0] sum1;

  serial_add_driver #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ready(ready1),
    .op_a(a1), .op_b(b1), .cin(cin1),
    .ser_clr(clr1), .ser_a(sa1), .ser_b(sb1), .ser_cin(sc1),
    .ser_s(s1), .ser_cout(co1), .sum(sum1), .done(done1));

  assign s1  = sa1 ^ sb1 ^ (sc1 | carry1);
  assign co1 = (sa1 & sb1) | ((sa1 ^ sb1) & (sc1 | carry1));
  always @(posedge clk or negedge reset)
    if (!reset) carry1 <= 1'b0;
    else        carry1 <= clr1 ? 1'b0 : co1;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [4:0] exp_sum;
  } vec_t;

  vec_t vecs [8];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One full add on the WIDTH=4 instance, checking every serial bit and the result.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] exp_sum);
    @(negedge clk);
    check_output("ready_before", {31'd0, ready4}, 32'd1);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      check_output("ser_a", {31'd0, sa4}, {31'd0, a[k]});
      check_output("ser_b", {31'd0, sb4}, {31'd0, b[k]});
      check_output("ser_cin", {31'd0, sc4}, (k == 0) ? {31'd0, c} : 32'd0);
      check_output("ser_clr_shift", {31'd0, clr4}, 32'd0);
      check_output("ready_shift", {31'd0, ready4}, 32'd0);
      check_output("done_early", {31'd0, done4}, 32'd0);
    end
    @(negedge clk);
    check_output("done", {31'd0, done4}, 32'd1);
    check_output("sum", {27'd0, sum4}, {27'd0, exp_sum});
    check_output("ser_clr_done", {31'd0, clr4}, 32'd1);
    check_output("ser_a_done", {31'd0, sa4}, 32'd0);
    @(negedge clk);
    check_output("done_pulse_end", {31'd0, done4}, 32'd0);
    check_output("ready_after", {31'd0, ready4}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{4'hF, 4'hB, 1'b1, 5'b11011};
    vecs[1] = '{4'h0, 4'h0, 1'b1, 5'b00001};
    vecs[2] = '{4'hF, 4'h1, 1'b0, 5'b10000};
    vecs[3] = '{4'h5, 4'hA, 1'b0, 5'd15};
    vecs[4] = '{4'hF, 4'hF, 1'b1, 5'd31};
    vecs[5] = '{4'h8, 4'h8, 1'b0, 5'd16};
    vecs[6] = '{4'h6, 4'h3, 1'b1, 5'd10};
    vecs[7] = '{4'h3, 4'h4, 1'b0, 5'd7};

    #2;
    check_output("rst_ready", {31'd0, ready4}, 32'd1);
    check_output("rst_ser_clr", {31'd0, clr4}, 32'd1);
    check_output("rst_ser_a", {31'd0, sa4}, 32'd0);
    check_output("rst_ser_cin", {31'd0, sc4}, 32'd0);
    check_output("rst_sum", {27'd0, sum4}, 32'd0);
    check_output("rst_done", {31'd0, done4}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 8; i++)
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp_sum);

    // Reset abort in the middle of SHIFT (counter = 2).
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk); start4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_output("abort_ready", {31'd0, ready4}, 32'd1);
    check_output("abort_sum", {27'd0, sum4}, 32'd0);
    check_output("abort_ser_clr", {31'd0, clr4}, 32'd1);
    check_output("abort_ser_a", {31'd0, sa4}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("abort_no_done", {31'd0, done4}, 32'd0);
    end
    apply_stimulus(4'h3, 4'h4, 1'b0, 5'd7);

    // start during SHIFT/DONE with new operands must be ignored.
    @(negedge clk);
    a4 = 4'h5; b4 = 4'h6; cin4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
    repeat (4) @(negedge clk);
    check_output("hs_done", {31'd0, done4}, 32'd1);
    check_output("hs_sum", {27'd0, sum4}, 32'd11);
    @(negedge clk);
    start4 = 1'b0;
    check_output("hs_ready", {31'd0, ready4}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("hs_no_done", {31'd0, done4}, 32'd0);
      check_output("hs_sum_hold", {27'd0, sum4}, 32'd11);
    end

    // start held high: two back-to-back adds, done pulses WIDTH+2 apart.
    begin
      int pulses = 0;
      int first_at = -1;
      int second_at = -1;
      @(negedge clk);
      a4 = 4'h2; b4 = 4'h3; cin4 = 1'b0; start4 = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 16; i++) begin
        @(negedge clk);
        if (i == 7) start4 = 1'b0;
        if (done4) begin
          pulses++;
          if (first_at < 0) first_at = i;
          else if (second_at < 0) second_at = i;
        end
      end
      check_output("b2b_pulses", pulses, 32'd2);
      check_output("b2b_first_latency", first_at, 32'd5);
      check_output("b2b_gap", second_at - first_at, 32'd6);
      check_output("b2b_sum", {27'd0, sum4}, 32'd5);
    end

    // WIDTH=5: 27 + 17 = 44, ser_clr low for exactly five cycles.
    begin
      int clr_low = 0;
      int done_seen = 0;
      @(negedge clk);
      a5 = 5'b11011; b5 = 5'b10001; cin5 = 1'b0; start5 = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 10; i++) begin
        @(negedge clk);
        start5 = 1'b0;
        if (!clr5) clr_low++;
        if (done5) begin
          done_seen++;
          check_output("w5_done_cycle", i, 32'd6);
          check_output("w5_sum", {26'd0, sum5}, 32'b101100);
        end
      end
      check_output("w5_clr_low", clr_low, 32'd5);
      check_output("w5_done_count", done_seen, 32'd1);
    end

    // WIDTH=1: one SHIFT cycle carrying both operand bits and carry-in.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0;
    check_output("w1_ser_a", {31'd0, sa1}, 32'd1);
    check_output("w1_ser_b", {31'd0, sb1}, 32'd1);
    check_output("w1_ser_cin", {31'd0, sc1}, 32'd1);
    check_output("w1_ser_clr", {31'd0, clr1}, 32'd0);
    @(negedge clk);
    check_output("w1_done", {31'd0, done1}, 32'd1);
    check_output("w1_sum", {30'd0, sum1}, 32'd3);
    @(negedge clk);
    check_output("w1_ready", {31'd0, ready1}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_driver.md
Name: serial_add_driver

Overview:
- Parallel-side front end for the bit-serial adder. It accepts two WIDTH-bit operands and a carry-in on a start/ready handshake.
- It streams the operands LSB-first into the serial adder, one bit per clock, and drives the adder's carry clear and carry-in.
- It collects the serial sum bits and the final carry into a parallel WIDTH+1-bit result, flagged by a one-cycle done pulse.
- It is the producer/consumer end of the serial adder's a/b/cin/s/cout interface.

Parameters:
- WIDTH, 4, operand width in bits; legal range 1..32.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when ready=1
- ready  output  1  high in IDLE only
- op_a  input  WIDTH  operand A; sampled on the accepting edge
- op_b  input  WIDTH  operand B; sampled on the accepting edge
- cin  input  1  carry-in; sampled on the accepting edge
- ser_clr  output  1  active-high clear of the adder carry flop
- ser_a  output  1  serial operand A bit
- ser_b  output  1  serial operand B bit
- ser_cin  output  1  serial carry-in; high only on the bit-0 cycle
- ser_s  input  1  adder sum bit; combinational from current inputs
- ser_cout  input  1  adder carry-out; combinational from current inputs
- sum  output  WIDTH+1  result {cout, s[WIDTH-1:0]}
- done  output  1  one-cycle pulse; sum valid from this cycle

Behaviour:
Reset (reset=0, asynchronous):
- state=IDLE, ready=1, ser_clr=1, ser_a=ser_b=ser_cin=0, sum=0, done=0.
- Internal shift registers and bit counter are cleared.

IDLE:
- ready=1, ser_clr=1, serial outputs 0.
- On an edge with start=1: latch op_a, op_b, cin; counter=0; go to SHIFT.

SHIFT (exactly WIDTH cycles, counter 0..WIDTH-1):
- ready=0, ser_clr=0.
- ser_a = latched A[counter], ser_b = latched B[counter].
- ser_cin = latched cin when counter=0, otherwise 0.
- All serial outputs are registered, so they change only on clock edges.
- At each edge, ser_s is captured into result bit [counter].
- At the edge ending counter=WIDTH-1, ser_cout is captured into sum[WIDTH]; go to DONE.

DONE (1 cycle):
- done=1, ready=0, ser_clr=1, serial outputs 0; next state IDLE.

Result and timing:
- sum is updated only on DONE entry and holds until the next DONE or reset.
- Latency: start edge, then WIDTH SHIFT cycles, then done at cycle WIDTH+1. Next accept is no earlier than the edge after DONE.
- Throughput: one add per WIDTH+2 cycles.
- Arithmetic: sum = op_a + op_b + cin, computed as unsigned values over WIDTH+1 bits. No overflow is possible.

Boundary conditions:
- start while ready=0 (SHIFT or DONE): ignored; no queuing.
- op_a, op_b or cin changing after acceptance: no effect on the running add.
- start held high continuously: a new add is accepted on each return to IDLE, giving back-to-back adds.
- Reset asserted mid-SHIFT: abort immediately to reset values; sum is cleared and done is not pulsed.
- WIDTH=1: exactly one SHIFT cycle, with ser_cin and the operand bit in the same cycle.

Test Plan:
- WIDTH=4, op_a=4'b1111, op_b=4'b1011, cin=1, start pulse: ser_a=1,1,1,1; ser_b=1,1,0,1; ser_cin=1,0,0,0. done occurs 5 cycles after accept with sum=5'b11011.
- WIDTH=5, op_a=5'b11011, op_b=5'b10001, cin=0: sum=6'b101100 with done. ser_clr is low for exactly 5 cycles.
- WIDTH=4, op_a=0, op_b=0, cin=1: sum=5'b00001. Then op_a=4'hF, op_b=4'h1, cin=0: sum=5'b10000 (carry ripples through every bit).
- Reset abort: reset=0 for 1 cycle at SHIFT counter=2. ready=1, sum=0 and ser_clr=1 immediately; no done pulse; a following add of 3+4 gives sum=7.
- Handshake: start pulsed during SHIFT and during DONE with different operands is ignored and the result is unchanged. With start held high for two adds, exactly two done pulses occur WIDTH+2 cycles apart.
